trdb_stimuli_player: RTL and testbench
======================================

Name: trdb_stimuli_player

Overview:
- Replays captured instruction-retire samples into the trace debugger's instruction interface, cycle by cycle.
- It is the playback end of the capture flow: samples are loaded into on-chip storage through a valid/ready port, then driven onto the same signal set the capture side records.
- Sits in the trace debugger testbench/FPGA harness in place of the core.
- Synthesizable; supports inter-sample gaps, looping and abort.

Parameters:
DEPTH, 64, number of sample entries (power of two, >=2)
CNT_W, 16, width of emitted-sample counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
load_valid_i  in  1  load sample offered
load_ready_o  out  1  load sample accepted when both high
load_sample_i  in  trdb_sample_t (108)  sample {valid,exception,interrupt,cause[4:0],tval[31:0],priv[2:0],iaddr[31:0],instr[31:0],compressed}
clear_i  in  1  empty the buffer (IDLE/DONE only)
start_i  in  1  begin playback
stop_i  in  1  abort playback / leave DONE
loop_i  in  1  wrap to first sample after last
gap_i  in  8  idle cycles inserted after each emitted sample
ivalid_o, iexception_o, interrupt_o  out  1 each  replayed fields
cause_o  out  5  replayed cause
tval_o  out  32  replayed tval
priv_o  out  3  replayed privilege
iaddr_o  out  32  replayed address
instr_o  out  32  replayed instruction
compressed_o  out  1  replayed compressed flag
busy_o  out  1  state is PLAY or GAP
done_o  out  1  state is DONE
count_o  out  $clog2(DEPTH)+1  samples stored
emitted_o  out  CNT_W  samples emitted since last start, wraps

Behaviour:
- Reset: state IDLE; count, rd_ptr, gap counter, emitted_o = 0; all replay outputs 0; busy_o = done_o = 0. Storage contents are not reset.
- States: IDLE, PLAY, GAP, DONE.
- Replay outputs are registered. They are all-zero in IDLE, GAP and DONE. Stored fields are driven verbatim, including a stored valid = 0, so idle cycles replay faithfully.
- Load: load_ready_o = (state==IDLE) && (count<DEPTH) && !clear_i. On handshake, write mem[count] and increment count. When full, ready is low and no overwrite occurs.
- clear_i in IDLE or DONE: count <= 0, next state IDLE. It takes priority over load and start. It is ignored in PLAY and GAP.
- IDLE, start_i, count>0 (cycle T0): outputs <= mem[0] at T1, rd_ptr <= 1, emitted_o <= 1, state PLAY. Start with count==0 is ignored.
- Sample k appears at cycle T1 + k*(1+gap). gap_i is sampled in the cycle a sample is emitted.
- PLAY, current sample is not the last:
  - gap==0: load next sample, increment emitted_o.
  - gap>0: go to GAP with counter = gap, outputs zero.
  - In GAP, decrement each cycle; at 1, load next sample and return to PLAY.
- Last sample (rd_ptr wrapped past count-1):
  - loop_i=1: next sample is mem[0]. The gap still applies before it.
  - loop_i=0: next cycle outputs zero, state DONE, done_o=1. No trailing gap.
- DONE: start_i replays from mem[0] exactly as from IDLE. stop_i or clear_i returns to IDLE.
- stop_i in PLAY or GAP: next cycle IDLE, outputs zero, rd_ptr 0, count preserved. stop_i beats start_i when both are asserted.
- emitted_o wraps modulo 2^CNT_W and holds its value in IDLE/DONE until the next start.
- DEPTH-wrap: rd_ptr width is $clog2(DEPTH). With count==DEPTH, the last index DEPTH-1 wraps naturally.
- Reset mid-playback: immediate async return to reset state. Outputs are zero in the same cycle.

Decomposition:
- trdb_pkg holds:
  - trdb_sample_t packed struct, field order as in the port list, valid is the MSB
  - SAMPLE_W = 108
  - player_state_e enum
- Sub-module trdb_sample_mem: DEPTH x SAMPLE_W flop array, one synchronous write port, one combinational read port, no reset on data.
- The player FSM and counters stay in trdb_stimuli_player.

Test Plan:
- Load 3 samples (iaddr 0x100/0x104/0x108, valid=1), gap_i=0, start → ivalid_o=1 with iaddr 0x100,0x104,0x108 on T1..T3; done_o=1 at T4; emitted_o=3.
- Same load, gap_i=2 → samples at T1,T4,T7; ivalid_o=0 and all outputs zero on T2,T3,T5,T6; done_o at T8.
- loop_i=1, 2 samples, gap 0 → iaddr alternates 0x100,0x104,0x100,... for 10 cycles; stop_i → outputs zero next cycle, busy_o=0, count_o still 2.
- Load DEPTH+2 samples with load_valid_i held → exactly DEPTH accepted, load_ready_o=0 thereafter, count_o=DEPTH. Playback emits mem[DEPTH-1] last, then DONE.
- Stored sample with valid=0, exception=1, cause=5'h02 → replayed verbatim on its cycle. Also: start with count=0 stays IDLE; clear_i together with load_valid_i → nothing written, count 0.
- Assert rst_i during GAP → outputs zero immediately, state IDLE, count_o=0; new load and start then work normally.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types for the trace-debugger stimuli player: the replayed sample
// layout and the playback state encoding.
package trdb_pkg;

  localparam int SAMPLE_W = 108;

  typedef struct packed {
    logic        valid;
    logic        exception;
    logic        interrupt;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [2:0]  priv;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        compressed;
  } trdb_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } player_state_e;

endpackage

// File: rtl/trdb_sample_mem.sv
// Sample storage: DEPTH x SAMPLE_W flop array, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module trdb_sample_mem
  import trdb_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  trdb_sample_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trdb_sample_t rdata_o
);

  trdb_sample_t mem_r [DEPTH];

  // Write port: data-only storage, no reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/trdb_stimuli_player.sv
// Replays stored instruction-retire samples onto the trace debugger's
// instruction interface, with optional inter-sample gaps, looping and abort.
module trdb_stimuli_player
  import trdb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  trdb_sample_t     load_sample_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             loop_i,
  input  logic [7:0]       gap_i,
  output logic             ivalid_o,
  output logic             iexception_o,
  output logic             interrupt_o,
  output logic [4:0]       cause_o,
  output logic [31:0]      tval_o,
  output logic [2:0]       priv_o,
  output logic [31:0]      iaddr_o,
  output logic [31:0]      instr_o,
  output logic             compressed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [AW:0]      count_o,
  output logic [CNT_W-1:0] emitted_o
);

  localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] EMIT_ONE = CNT_W'(1);

  player_state_e    state_r, state_n;
  logic [AW:0]      count_r, count_n;
  logic [AW-1:0]    rd_ptr_r, rd_ptr_n;
  logic [7:0]       gap_cnt_r, gap_cnt_n;
  logic [CNT_W-1:0] emitted_r, emitted_n;
  trdb_sample_t     out_r, out_n;

  logic             load_ready_s;
  logic             we_s;
  logic             last_s;
  logic [AW-1:0]    rd_addr_s;
  trdb_sample_t     rd_data_s;

  assign load_ready_s = (state_r == ST_IDLE) && (count_r < CNT_FULL) && !clear_i;
  assign we_s         = load_valid_i && load_ready_s;
  // With count == DEPTH the low bits are zero, matching the naturally wrapped pointer.
  assign last_s       = (rd_ptr_r == count_r[AW-1:0]);

  trdb_sample_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .waddr_i (count_r[AW-1:0]),
    .wdata_i (load_sample_i),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Read address: index of the sample that would be emitted next
  always_comb begin
    rd_addr_s = '0;
    case (state_r)
      ST_PLAY: begin
        if (last_s) begin
          rd_addr_s = '0;
        end else begin
          rd_addr_s = rd_ptr_r;
        end
      end
      ST_GAP:  rd_addr_s = rd_ptr_r;
      default: rd_addr_s = '0;
    endcase
  end

  // Next-state, counters and replay data
  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    rd_ptr_n  = rd_ptr_r;
    gap_cnt_n = gap_cnt_r;
    emitted_n = emitted_r;
    out_n     = '0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (clear_i) begin
          count_n = '0;
        end else if (we_s) begin
          count_n = count_r + CNT_ONE;
        end else begin
          count_n = count_r;
        end
        if (clear_i) begin
          state_n = ST_IDLE;
        end else if ((state_r == ST_DONE) && stop_i) begin
          state_n = ST_IDLE;
        end else if (start_i && (count_r != '0)) begin
          out_n     = rd_data_s;
          rd_ptr_n  = PTR_ONE;
          emitted_n = EMIT_ONE;
          state_n   = ST_PLAY;
        end else begin
          state_n = state_r;
        end
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_n  = ST_IDLE;
          rd_ptr_n = '0;
        end else if (last_s && !loop_i) begin
          state_n  = ST_DONE;
          rd_ptr_n = '0;
        end else if (gap_i == 8'd0) begin
          out_n     = rd_data_s;
          rd_ptr_n  = rd_addr_s + PTR_ONE;
          emitted_n = emitted_r + EMIT_ONE;
        end else begin
          // Park the pointer on the upcoming sample (mem[0] when looping).
          state_n   = ST_GAP;
          gap_cnt_n = gap_i;
          rd_ptr_n  = rd_addr_s;
        end
      end
      ST_GAP: begin
        if (stop_i) begin
          state_n   = ST_IDLE;
          rd_ptr_n  = '0;
          gap_cnt_n = 8'd0;
        end else if (gap_cnt_r == 8'd1) begin
          out_n     = rd_data_s;
          rd_ptr_n  = rd_ptr_r + PTR_ONE;
          emitted_n = emitted_r + EMIT_ONE;
          gap_cnt_n = 8'd0;
          state_n   = ST_PLAY;
        end else begin
          gap_cnt_n = gap_cnt_r - 8'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      count_r   <= '0;
      rd_ptr_r  <= '0;
      gap_cnt_r <= 8'd0;
      emitted_r <= '0;
      out_r     <= '0;
    end else begin
      state_r   <= state_n;
      count_r   <= count_n;
      rd_ptr_r  <= rd_ptr_n;
      gap_cnt_r <= gap_cnt_n;
      emitted_r <= emitted_n;
      out_r     <= out_n;
    end
  end

  assign load_ready_o = load_ready_s;
  assign ivalid_o     = out_r.valid;
  assign iexception_o = out_r.exception;
  assign interrupt_o  = out_r.interrupt;
  assign cause_o      = out_r.cause;
  assign tval_o       = out_r.tval;
  assign priv_o       = out_r.priv;
  assign iaddr_o      = out_r.iaddr;
  assign instr_o      = out_r.instr;
  assign compressed_o = out_r.compressed;
  assign busy_o       = (state_r == ST_PLAY) || (state_r == ST_GAP);
  assign done_o       = (state_r == ST_DONE);
  assign count_o      = count_r;
  assign emitted_o    = emitted_r;

endmodule

// File: tb/tb_trdb_stimuli_player.sv
// Directed, table-driven bench for trdb_stimuli_player (DEPTH = 8).
module tb_trdb_stimuli_player;
  import trdb_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic load_ready;
  trdb_sample_t load_sample = '0;
  logic clear = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [7:0] gap = 8'd0;
  logic ivalid, iexception, interrupt, compressed, busy, done;
  logic [4:0] cause;
  logic [31:0] tval, iaddr, instr;
  logic [2:0] priv;
  logic [3:0] count;
  logic [CNT_W-1:0] emitted;
  trdb_sample_t obs;

  int n_chk = 0;
  int n_fail = 0;
  trdb_sample_t stored [DEPTH];

  trdb_stimuli_player #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .load_valid_i(load_valid), .load_ready_o(load_ready), .load_sample_i(load_sample),
    .clear_i(clear), .start_i(start), .stop_i(stop), .loop_i(loop), .gap_i(gap),
    .ivalid_o(ivalid), .iexception_o(iexception), .interrupt_o(interrupt),
    .cause_o(cause), .tval_o(tval), .priv_o(priv), .iaddr_o(iaddr), .instr_o(instr),
    .compressed_o(compressed), .busy_o(busy), .done_o(done),
    .count_o(count), .emitted_o(emitted)
  );

  always #5 clk = ~clk;

  assign obs = {ivalid, iexception, interrupt, cause, tval, priv, iaddr, instr, compressed};

  typedef struct {
    logic        start;
    logic [7:0]  gap;
    int          sidx;
    logic        busy;
    logic        done;
    logic [15:0] em;
  } vec_t;

  vec_t vt [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic trdb_sample_t mk(input logic [31:0] addr);
    trdb_sample_t s;
    s            = '0;
    s.valid      = 1'b1;
    s.iaddr      = addr;
    s.instr      = {addr[15:0], 16'h0013};
    s.priv       = 3'd3;
    s.tval       = addr ^ 32'h0000_F0F0;
    s.compressed = addr[2];
    return s;
  endfunction

  task automatic load(input int idx, input trdb_sample_t s);
    load_valid  = 1'b1;
    load_sample = s;
    stored[idx] = s;
    tick();
    load_valid  = 1'b0;
  endtask

  trdb_sample_t exp_s;
  int accepted;

  initial begin
    // gap 0 run, then restart from DONE with gap 2
    vt[0]  = '{1'b1, 8'd0, 0,  1'b1, 1'b0, 16'd1};
    vt[1]  = '{1'b0, 8'd0, 1,  1'b1, 1'b0, 16'd2};
    vt[2]  = '{1'b0, 8'd0, 2,  1'b1, 1'b0, 16'd3};
    vt[3]  = '{1'b0, 8'd0, -1, 1'b0, 1'b1, 16'd3};
    vt[4]  = '{1'b1, 8'd2, 0,  1'b1, 1'b0, 16'd1};
    vt[5]  = '{1'b0, 8'd2, -1, 1'b1, 1'b0, 16'd1};
    vt[6]  = '{1'b0, 8'd2, -1, 1'b1, 1'b0, 16'd1};
    vt[7]  = '{1'b0, 8'd2, 1,  1'b1, 1'b0, 16'd2};
    vt[8]  = '{1'b0, 8'd2, -1, 1'b1, 1'b0, 16'd2};
    vt[9]  = '{1'b0, 8'd2, -1, 1'b1, 1'b0, 16'd2};
    vt[10] = '{1'b0, 8'd2, 2,  1'b1, 1'b0, 16'd3};
    vt[11] = '{1'b0, 8'd2, -1, 1'b0, 1'b1, 16'd3};

    tick();
    tick();
    rst = 1'b0;
    chk("reset_out", 128'(obs), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_emitted", 128'(emitted), 128'(0));
    chk("reset_ready", 128'(load_ready), 128'(1));

    load(0, mk(32'h100));
    load(1, mk(32'h104));
    load(2, mk(32'h108));
    chk("count3", 128'(count), 128'(3));

    for (int i = 0; i < 12; i++) begin
      start = vt[i].start;
      gap   = vt[i].gap;
      tick();
      start = 1'b0;
      exp_s = (vt[i].sidx < 0) ? trdb_sample_t'('0) : stored[vt[i].sidx];
      chk($sformatf("vec%0d_out", i), 128'(obs), 128'(exp_s));
      chk($sformatf("vec%0d_busy", i), 128'(busy), 128'(vt[i].busy));
      chk($sformatf("vec%0d_done", i), 128'(done), 128'(vt[i].done));
      chk($sformatf("vec%0d_emitted", i), 128'(emitted), 128'(vt[i].em));
    end
    gap = 8'd0;

    // DONE -> IDLE on stop, then clear
    stop = 1'b1; tick(); stop = 1'b0;
    chk("done_stop", 128'(done), 128'(0));
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_count", 128'(count), 128'(0));

    // loop over two samples, gap 0
    load(0, mk(32'h100));
    load(1, mk(32'h104));
    loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      chk($sformatf("loop%0d_iaddr", c), 128'(iaddr), 128'((c % 2 == 1) ? 32'h104 : 32'h100));
      chk($sformatf("loop%0d_valid", c), 128'(ivalid), 128'(1));
    end
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("stop_out", 128'(obs), 128'(0));
    chk("stop_busy", 128'(busy), 128'(0));
    chk("stop_done", 128'(done), 128'(0));
    chk("stop_count", 128'(count), 128'(2));
    tick();
    chk("stop_beats_start", 128'(busy), 128'(0));

    // loop with gap 1: gap also precedes the wrap to mem[0]
    gap = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("lg_t1", 128'(obs), 128'(stored[0]));
    tick(); chk("lg_t2", 128'(obs), 128'(0));
    tick(); chk("lg_t3", 128'(obs), 128'(stored[1]));
    tick(); chk("lg_t4", 128'(obs), 128'(0));
    tick(); chk("lg_t5", 128'(obs), 128'(stored[0]));
    chk("lg_emitted", 128'(emitted), 128'(3));
    stop = 1'b1; tick(); stop = 1'b0;
    loop = 1'b0;
    gap = 8'd0;

    // clear with load offered, then start on an empty buffer
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear2_count", 128'(count), 128'(0));
    clear = 1'b1; load_valid = 1'b1; load_sample = mk(32'h300);
    #1;
    chk("clear_ready", 128'(load_ready), 128'(0));
    tick();
    clear = 1'b0; load_valid = 1'b0;
    chk("clear_load_count", 128'(count), 128'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start_busy", 128'(busy), 128'(0));
    chk("empty_start_out", 128'(obs), 128'(0));

    // fill past capacity with load_valid held
    accepted = 0;
    load_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      exp_s = mk(32'h200 + 32'(4 * i));
      if (i == 3) begin
        exp_s           = '0;
        exp_s.exception = 1'b1;
        exp_s.cause     = 5'h02;
        exp_s.iaddr     = 32'h20C;
      end
      load_sample = exp_s;
      if (i < DEPTH) stored[i] = exp_s;
      #1;
      if (load_ready) accepted++;
      tick();
    end
    chk("fill_accepted", 128'(accepted), 128'(DEPTH));
    chk("fill_ready", 128'(load_ready), 128'(0));
    chk("fill_count", 128'(count), 128'(DEPTH));
    load_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) tick();
      chk($sformatf("full%0d_out", i), 128'(obs), 128'(stored[i]));
    end
    tick();
    chk("full_done", 128'(done), 128'(1));
    chk("full_done_out", 128'(obs), 128'(0));
    chk("full_emitted", 128'(emitted), 128'(DEPTH));

    // async reset during GAP, then normal operation
    stop = 1'b1; tick(); stop = 1'b0;
    gap = 8'd3;
    start = 1'b1; tick(); start = 1'b0;
    chk("rg_t1", 128'(obs), 128'(stored[0]));
    tick();
    chk("rg_gap_busy", 128'(busy), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rg_out", 128'(obs), 128'(0));
    chk("rg_busy", 128'(busy), 128'(0));
    chk("rg_count", 128'(count), 128'(0));
    chk("rg_emitted", 128'(emitted), 128'(0));
    tick();
    rst = 1'b0;
    gap = 8'd0;
    load(0, mk(32'h400));
    chk("rg_reload_count", 128'(count), 128'(1));
    start = 1'b1; tick(); start = 1'b0;
    chk("rg_play_out", 128'(obs), 128'(stored[0]));
    chk("rg_play_emitted", 128'(emitted), 128'(1));
    tick();
    chk("rg_play_done", 128'(done), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
